// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and defaults for the fetch/data memory port arbiter.
//   ADDR_W_DEF / DATA_W_DEF : default address and data widths
//   arb_state_e             : arbiter FSM states
//   req_id_e                : requester identity (fetch or data port)
//   other_id()              : the requester that is not the given one
package mem_arb_pkg;

  localparam int ADDR_W_DEF = 64;
  localparam int DATA_W_DEF = 64;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } arb_state_e;

  typedef enum logic {
    REQ_I = 1'b0,
    REQ_D = 1'b1
  } req_id_e;

  function automatic req_id_e other_id(input req_id_e id);
    return (id == REQ_I) ? REQ_D : REQ_I;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker, purely combinational.
//   req   : request vector, bit 0 = fetch (REQ_I), bit 1 = data (REQ_D)
//   last  : requester granted most recently
//   grant : selected requester; only meaningful when req is non-zero
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  req_id_e    last,
  output req_id_e    grant
);

  // Lone requester wins; on a tie the one not served last wins.
  always_comb begin
    grant = last;
    case (req)
      2'b01:   grant = REQ_I;
      2'b10:   grant = REQ_D;
      2'b11:   grant = other_id(last);
      default: grant = last;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates a fetch port (i_*) and a data port (d_*) onto a single cache
// port (m_*). One transaction is in flight at a time: grant, wait for the
// cache completion, then one response cycle back to the owner.
//   clk, reset           : clock, synchronous active-high reset
//   i_req/i_addr         : fetch request, held until i_gnt
//   i_cancel             : fetch redirect, discards the in-flight fetch data
//   i_gnt/i_valid/i_rdata: fetch accept pulse, response pulse and data
//   d_req/d_write/d_addr/d_wdata/d_be : data request, held until d_gnt
//   d_gnt/d_valid/d_rdata: data accept pulse, response pulse, load data
//   m_req/m_write/m_addr/m_wdata/m_be : latched cache request, level
//   m_rdata/m_data_valid/m_write_complete : cache responses
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  input  logic                i_cancel,
  output logic                i_gnt,
  output logic                i_valid,
  output logic [DATA_W-1:0]   i_rdata,
  input  logic                d_req,
  input  logic                d_write,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_be,
  output logic                d_gnt,
  output logic                d_valid,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                m_req,
  output logic                m_write,
  output logic [ADDR_W-1:0]   m_addr,
  output logic [DATA_W-1:0]   m_wdata,
  output logic [DATA_W/8-1:0] m_be,
  input  logic [DATA_W-1:0]   m_rdata,
  input  logic                m_data_valid,
  input  logic                m_write_complete
);

  localparam int BE_W = DATA_W / 8;

  arb_state_e state_r;
  req_id_e    owner_r;
  req_id_e    last_grant_r;
  logic       drop_r;

  logic [1:0] req_vec_s;
  req_id_e    pick_s;
  logic       done_s;
  logic       drop_now_s;

  assign req_vec_s = {d_req, i_req};

  rr_arb2 u_rr_arb2 (
    .req   (req_vec_s),
    .last  (last_grant_r),
    .grant (pick_s)
  );

  // Only the response matching the latched direction completes a transaction.
  assign done_s = (state_r == ST_BUSY) &&
                  (m_write ? m_write_complete : m_data_valid);

  // A cancel seen in the completion cycle itself still drops the fetch.
  assign drop_now_s = drop_r || ((owner_r == REQ_I) && i_cancel);

  // FSM, cache request latch and registered responses.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      owner_r      <= REQ_I;
      last_grant_r <= REQ_I;
      drop_r       <= 1'b0;
      m_req        <= 1'b0;
      m_write      <= 1'b0;
      m_addr       <= {ADDR_W{1'b0}};
      m_wdata      <= {DATA_W{1'b0}};
      m_be         <= {BE_W{1'b0}};
      i_gnt        <= 1'b0;
      d_gnt        <= 1'b0;
      i_valid      <= 1'b0;
      d_valid      <= 1'b0;
      i_rdata      <= {DATA_W{1'b0}};
      d_rdata      <= {DATA_W{1'b0}};
    end else begin
      i_gnt   <= 1'b0;
      d_gnt   <= 1'b0;
      i_valid <= 1'b0;
      d_valid <= 1'b0;
      case (state_r)
        // RESP arbitrates like IDLE so a waiting requester is granted in the
        // cycle right after the response pulse.
        ST_IDLE, ST_RESP: begin
          if (|req_vec_s) begin
            state_r      <= ST_BUSY;
            owner_r      <= pick_s;
            last_grant_r <= pick_s;
            drop_r       <= 1'b0;
            m_req        <= 1'b1;
            if (pick_s == REQ_D) begin
              m_write <= d_write;
              m_addr  <= d_addr;
              m_wdata <= d_wdata;
              m_be    <= d_be;
              d_gnt   <= 1'b1;
            end else begin
              m_write <= 1'b0;
              m_addr  <= i_addr;
              m_wdata <= {DATA_W{1'b0}};
              m_be    <= {BE_W{1'b1}};
              i_gnt   <= 1'b1;
            end
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_BUSY: begin
          if ((owner_r == REQ_I) && i_cancel) begin
            drop_r <= 1'b1;
          end else begin
            drop_r <= drop_r;
          end
          if (done_s) begin
            state_r <= ST_RESP;
            m_req   <= 1'b0;
            if (owner_r == REQ_D) begin
              d_valid <= 1'b1;
              d_rdata <= m_write ? {DATA_W{1'b0}} : m_rdata;
            end else if (!drop_now_s) begin
              i_valid <= 1'b1;
              i_rdata <= m_rdata;
            end else begin
              i_valid <= 1'b0;
            end
          end else begin
            state_r <= ST_BUSY;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          m_req   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench: drivers push the expected response of every granted,
// non-cancelled request; a negedge monitor pops and compares on each valid
// pulse and also checks round-robin order of grants.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_req, i_cancel, d_req, d_write;
  logic [63:0] i_addr, d_addr, d_wdata, m_rdata;
  logic [7:0]  d_be;
  logic        m_data_valid, m_write_complete;
  logic        i_gnt, i_valid, d_gnt, d_valid, m_req, m_write;
  logic [63:0] i_rdata, d_rdata, m_addr, m_wdata;
  logic [7:0]  m_be;

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_i_q[$];
  logic [63:0] exp_d_q[$];

  // cache model controls
  int          force_dly = 0;
  int          stray_lvl = 0;
  bit          force_data_en = 1'b0;
  logic [63:0] force_data = 64'h0;

  mem_port_arbiter dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_cancel(i_cancel),
    .i_gnt(i_gnt), .i_valid(i_valid), .i_rdata(i_rdata),
    .d_req(d_req), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_gnt(d_gnt), .d_valid(d_valid), .d_rdata(d_rdata),
    .m_req(m_req), .m_write(m_write), .m_addr(m_addr), .m_wdata(m_wdata), .m_be(m_be),
    .m_rdata(m_rdata), .m_data_valid(m_data_valid), .m_write_complete(m_write_complete)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] hash(input logic [63:0] a);
    return {a[31:0], a[63:32]} ^ 64'h0123_4567_89AB_CDEF;
  endfunction

  function automatic logic stray_bit();
    if (stray_lvl == 2) return 1'b1;
    if (stray_lvl == 1) return 1'($urandom_range(0, 1));
    return 1'b0;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s actual=timeout expected=event", name);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Fetch driver: hold until grant, check latched fields, optionally cancel.
  task automatic issue_i(input logic [63:0] addr, input int cancel_dly, output int waits);
    bit got = 1'b0;
    i_addr = addr;
    i_req  = 1'b1;
    waits  = 0;
    for (int n = 0; n < 300; n++) begin
      step();
      waits++;
      if (i_gnt) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      fail_now("i_gnt_wait");
      i_req = 1'b0;
      return;
    end
    chk("i_m_addr", m_addr, addr);
    chk("i_m_write", {63'h0, m_write}, 64'h0);
    chk("i_m_req", {63'h0, m_req}, 64'h1);
    i_req = 1'b0;
    if (cancel_dly < 0) begin
      exp_i_q.push_back(force_data_en ? force_data : hash(addr));
    end else begin
      for (int n = 0; n < cancel_dly; n++) step();
      i_cancel = 1'b1;
      step();
      i_cancel = 1'b0;
    end
  endtask

  // Data driver: hold until grant, check latched fields, push expectation.
  task automatic issue_d(input bit wr, input logic [63:0] addr, input logic [63:0] wdata,
                         input logic [7:0] be, output int waits);
    bit got = 1'b0;
    d_write = wr;
    d_addr  = addr;
    d_wdata = wdata;
    d_be    = be;
    d_req   = 1'b1;
    waits   = 0;
    for (int n = 0; n < 300; n++) begin
      step();
      waits++;
      if (d_gnt) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      fail_now("d_gnt_wait");
      d_req = 1'b0;
      return;
    end
    chk("d_m_write", {63'h0, m_write}, {63'h0, wr});
    chk("d_m_addr", m_addr, addr);
    chk("d_m_be", {56'h0, m_be}, {56'h0, be});
    if (wr) chk("d_m_wdata", m_wdata, wdata);
    d_req = 1'b0;
    exp_d_q.push_back(wr ? 64'h0 : (force_data_en ? force_data : hash(addr)));
  endtask

  task automatic drain();
    for (int n = 0; n < 300; n++) begin
      if (exp_i_q.size() == 0 && exp_d_q.size() == 0) break;
      step();
    end
    if (exp_i_q.size() != 0 || exp_d_q.size() != 0) fail_now("drain");
    repeat (3) step();
  endtask

  // Cache model: answers each m_req after a delay; may toggle the response
  // signal that does not apply, and raises strays while m_req is low.
  initial begin
    int  cnt = 0;
    int  dly = 2;
    bit  done = 1'b0;
    m_data_valid = 1'b0;
    m_write_complete = 1'b0;
    m_rdata = 64'h0;
    forever begin
      step();
      m_data_valid = 1'b0;
      m_write_complete = 1'b0;
      if (m_req && !done) begin
        cnt++;
        if (cnt >= dly) begin
          done = 1'b1;
          if (m_write) begin
            m_write_complete = 1'b1;
            m_data_valid = stray_bit();
            m_rdata = {$urandom, $urandom};
          end else begin
            m_data_valid = 1'b1;
            m_write_complete = stray_bit();
            m_rdata = force_data_en ? force_data : hash(m_addr);
          end
        end else begin
          if (m_write) m_data_valid = stray_bit();
          else m_write_complete = stray_bit();
          m_rdata = {$urandom, $urandom};
        end
      end else if (!m_req) begin
        cnt = 0;
        done = 1'b0;
        dly = (force_dly != 0) ? force_dly : $urandom_range(1, 6);
        m_data_valid = stray_bit();
        m_write_complete = stray_bit();
        m_rdata = {$urandom, $urandom};
      end
    end
  end

  // Monitor: response scoreboard, data hold, round-robin grant order.
  initial begin
    logic [63:0] last_i = 64'h0;
    logic [63:0] last_d = 64'h0;
    bit          last_gd = 1'b0;
    bit          prev_i = 1'b0;
    bit          prev_d = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        exp_i_q.delete();
        exp_d_q.delete();
        last_i = 64'h0;
        last_d = 64'h0;
        last_gd = 1'b0;
      end else begin
        if (i_valid) begin
          if (exp_i_q.size() == 0) begin
            chk("i_valid_unexpected", {63'h0, i_valid}, 64'h0);
          end else begin
            last_i = exp_i_q.pop_front();
            chk("i_rdata", i_rdata, last_i);
          end
        end else begin
          chk("i_rdata_hold", i_rdata, last_i);
        end
        if (d_valid) begin
          if (exp_d_q.size() == 0) begin
            chk("d_valid_unexpected", {63'h0, d_valid}, 64'h0);
          end else begin
            last_d = exp_d_q.pop_front();
            chk("d_rdata", d_rdata, last_d);
          end
        end else begin
          chk("d_rdata_hold", d_rdata, last_d);
        end
        if (i_gnt || d_gnt) begin
          chk("gnt_onehot", {63'h0, i_gnt & d_gnt}, 64'h0);
          if (prev_i && prev_d) chk("rr_tie_winner_d", {63'h0, d_gnt}, {63'h0, !last_gd});
          else chk("single_winner_d", {63'h0, d_gnt}, {63'h0, prev_d});
          last_gd = d_gnt;
        end
      end
      prev_i = i_req;
      prev_d = d_req;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    int ng;
    bit order[$];
    reset = 1'b1;
    i_req = 1'b0; i_cancel = 1'b0; i_addr = 64'h0;
    d_req = 1'b0; d_write = 1'b0; d_addr = 64'h0; d_wdata = 64'h0; d_be = 8'h0;
    repeat (3) step();
    chk("rst_m_req", {63'h0, m_req}, 64'h0);
    chk("rst_m_addr", m_addr, 64'h0);
    chk("rst_i_rdata", i_rdata, 64'h0);
    chk("rst_valids", {62'h0, i_valid, d_valid}, 64'h0);
    reset = 1'b0;

    // single fetch, data 3 cycles after m_req
    force_dly = 4; force_data_en = 1'b1; force_data = 64'hDEAD; stray_lvl = 0;
    step();
    issue_i(64'h1000, -1, w);
    chk("t1_gnt_cycle", w, 1);
    repeat (3) step();
    chk("t1_no_valid_c4", {63'h0, i_valid}, 64'h0);
    step();
    chk("t1_valid_c5", {63'h0, i_valid}, 64'h1);
    chk("t1_rdata_c5", i_rdata, 64'hDEAD);
    force_data_en = 1'b0;
    drain();

    // simultaneous requests after reset alternate D, I, D
    reset = 1'b1; step(); step(); reset = 1'b0;
    force_dly = 2;
    step();
    i_addr = 64'h3000; d_addr = 64'h4000; d_write = 1'b0; d_be = 8'hFF;
    i_req = 1'b1; d_req = 1'b1; ng = 0;
    for (int n = 0; n < 100 && ng < 3; n++) begin
      step();
      if (i_gnt) begin exp_i_q.push_back(hash(i_addr)); order.push_back(1'b0); i_addr += 64'h8; ng++; end
      if (d_gnt) begin exp_d_q.push_back(hash(d_addr)); order.push_back(1'b1); d_addr += 64'h8; ng++; end
    end
    i_req = 1'b0; d_req = 1'b0;
    chk("t2_ngrants", ng, 3);
    if (order.size() == 3) begin
      chk("t2_order", {61'h0, order[0], order[1], order[2]}, 64'h5);
    end else begin
      fail_now("t2_order");
    end
    drain();

    // store with stray data_valid before write_complete
    stray_lvl = 2; force_dly = 4;
    step();
    issue_d(1'b1, 64'h2000, 64'h55, 8'h0F, w);
    chk("t3_gnt_cycle", w, 1);
    repeat (3) step();
    chk("t3_no_valid_c4", {63'h0, d_valid}, 64'h0);
    step();
    chk("t3_valid_c5", {63'h0, d_valid}, 64'h1);
    chk("t3_rdata_zero", d_rdata, 64'h0);
    stray_lvl = 0;
    drain();

    // fetch cancelled mid-wait still completes on the cache side
    force_dly = 4;
    step();
    issue_i(64'h5000, 1, w);
    chk("t4_m_req_c3", {63'h0, m_req}, 64'h1);
    step();
    chk("t4_m_req_c4", {63'h0, m_req}, 64'h1);
    step();
    chk("t4_m_req_c5", {63'h0, m_req}, 64'h0);
    chk("t4_no_valid_c5", {63'h0, i_valid}, 64'h0);
    step();
    chk("t4_no_valid_c6", {63'h0, i_valid}, 64'h0);
    issue_i(64'h6000, -1, w);
    drain();

    // reset during BUSY, late cache responses ignored
    force_dly = 6;
    step();
    issue_i(64'h7000, -1, w);
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("t5_m_req", {63'h0, m_req}, 64'h0);
    chk("t5_i_rdata", i_rdata, 64'h0);
    stray_lvl = 2;
    for (int n = 0; n < 6; n++) begin
      step();
      chk("t5_quiet", {61'h0, m_req, i_valid, d_valid}, 64'h0);
    end
    stray_lvl = 1; force_dly = 0;
    issue_d(1'b0, 64'h8000, 64'h0, 8'hFF, w);
    chk("t5_idle_gnt", w, 1);
    drain();

    // randomized traffic on both ports
    fork
      begin
        int wi;
        for (int n = 0; n < 30; n++) begin
          int g = $urandom_range(0, 3);
          for (int k = 0; k < g; k++) begin
            i_cancel = 1'($urandom_range(0, 1));
            step();
          end
          i_cancel = 1'b0;
          issue_i({$urandom, $urandom}, ($urandom_range(0, 3) == 0) ? 0 : -1, wi);
          for (int k = 0; k < 200 && exp_i_q.size() != 0; k++) step();
        end
      end
      begin
        int wd;
        for (int n = 0; n < 30; n++) begin
          int g = $urandom_range(0, 3);
          for (int k = 0; k < g; k++) step();
          issue_d(1'($urandom_range(0, 1)), {$urandom, $urandom}, {$urandom, $urandom},
                  8'($urandom_range(0, 255)), wd);
        end
      end
    join
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter ADDR_W, 64, address width of all ports.
REQ-002 Parameter DATA_W, 64, data width; byte-enable width = DATA_W/8.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 i_req  in  1  fetch read request; held with i_addr until i_gnt.
REQ-006 i_addr  in  ADDR_W  fetch address.
REQ-007 i_cancel  in  1  fetch redirect; drops the in-flight fetch response.
REQ-008 i_gnt  out  1  one-cycle pulse: fetch request accepted.
REQ-009 i_valid  out  1  one-cycle pulse: i_rdata valid.
REQ-010 i_rdata  out  DATA_W  fetched data.
REQ-011 d_req  in  1  data request; held with d_write/d_addr/d_wdata/d_be until d_gnt.
REQ-012 d_write  in  1  1 = store, 0 = load.
REQ-013 d_addr  in  ADDR_W; d_wdata  in  DATA_W; d_be  in  DATA_W/8.
REQ-014 d_gnt  out  1  one-cycle pulse: data request accepted.
REQ-015 d_valid  out  1  one-cycle pulse: load data valid or store complete.
REQ-016 d_rdata  out  DATA_W  load data (0 for stores).
REQ-017 m_req  out  1  cache read/write enable, level, held until completion.
REQ-018 m_write  out  1; m_addr  out  ADDR_W; m_wdata  out  DATA_W; m_be  out  DATA_W/8: latched request fields.
REQ-019 m_rdata  in  DATA_W; m_data_valid  in  1; m_write_complete  in  1: cache responses.

Function
REQ-020 States IDLE, BUSY, RESP; all outputs registered.
REQ-021 IDLE: no request -> stay; any request -> BUSY next cycle, latch winner fields into m_*, m_req=1, winner gnt=1 for exactly that first BUSY cycle.
REQ-022 Arbitration round-robin: single requester wins; both requesting -> requester not granted last wins; last_grant updates on every grant.
REQ-023 BUSY: m_req and m_* stay constant until completion; completion = m_data_valid for reads, m_write_complete for writes; the other response signal is ignored.
REQ-024 On completion cycle: capture m_rdata, go to RESP; m_req=0 from the next cycle.
REQ-025 RESP: exactly one cycle, pulses i_valid or d_valid for the owner with captured data; then IDLE.
REQ-026 Minimum latency: request seen cycle 0 -> gnt/m_req cycle 1 -> completion cycle k>=1 -> valid cycle k+1 -> next grant earliest cycle k+2.
REQ-027 i_cancel high in any cycle from i_gnt through the I completion cycle sets a drop flag; i_valid suppressed in RESP; the memory transaction still completes.
REQ-028 i_cancel in IDLE, or during a D transaction, has no effect.
REQ-029 Completion inputs in IDLE or RESP are ignored.
REQ-030 i_rdata/d_rdata hold last value when not valid; non-owner valid stays 0.

Reset
REQ-031 Reset -> state IDLE, last_grant = I (D wins first tie), drop flag 0.
REQ-032 Reset -> m_req, m_write, i_gnt, d_gnt, i_valid, d_valid = 0; m_addr, m_wdata, m_be, i_rdata, d_rdata = 0.
REQ-033 Reset mid-transaction aborts it; no valid issued; late cache responses ignored.

Structure
REQ-034 Package mem_arb_pkg holds state enum, requester-id enum {REQ_I, REQ_D}, ADDR_W/DATA_W defaults.
REQ-035 One sub-module rr_arb2: combinational 2-way round-robin picker (req[1:0], last -> grant id).

Verification
REQ-036 i_req, i_addr=0x1000 alone; cache data_valid 3 cycles after m_req with 0xDEAD -> i_gnt cycle 1, m_addr=0x1000, i_valid with i_rdata=0xDEAD cycle 5.
REQ-037 i_req and d_req simultaneous after reset, both held -> D granted first, I second, D third (alternation).
REQ-038 d_write=1, d_addr=0x2000, d_wdata=0x55, d_be=0x0F; cache asserts stray m_data_valid then m_write_complete -> completion only on write_complete, d_valid=1, d_rdata=0.
REQ-039 I fetch, i_cancel pulsed one cycle mid-wait -> m_req held to completion, i_valid never asserted, next request granted normally.
REQ-040 reset asserted during BUSY, then cache completion arrives -> m_req=0 after reset, no i_valid/d_valid, state IDLE.
